// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-write target.
package i2c_pkg;
  localparam int BYTE_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, IGNORE
  } state_e;
endpackage

// File: rtl/i2c_in_filter.sv
// Pad synchronizer plus run-length glitch filter; emits registered edge flags
// in the same cycle the filtered level changes.
module i2c_in_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             cnt_q;
  logic                   s_in;

  assign s_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      dout   <= 1'b1;
      cnt_q  <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;
      // The level flips only after FILT_LEN consecutive disagreeing samples.
      if (s_in == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == 3'(FILT_LEN - 1)) begin
        dout  <= s_in;
        rise  <= s_in;
        fall  <= ~s_in;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end
endmodule

// File: rtl/i2c_reg_writer.sv
// Write-only I2C target: address match, ACK via open-drain enable, and
// sub-address/data bytes turned into register-write strobes.
module i2c_reg_writer
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h2A,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(clk), .rst(rst), .din(scl_in), .dout(scl_f), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(clk), .rst(rst), .din(sda_in), .dout(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_d, wr_en_d, busy_d;
  logic [7:0] wr_addr_d, wr_data_d;
  logic       start_det, stop_det;
  logic [7:0] byte_in;

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign byte_in   = {shift_q[6:0], sda_f};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    busy_d    = busy;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      shift_d   = '0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, SUB, DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(BYTE_BITS - 1)) begin
              bit_cnt_d = '0;
              if (state_q == ADDR) begin
                if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == SUB) begin
                ptr_d   = byte_in;
                state_d = SUB_ACK;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_q + 8'd1;
                state_d   = DATA_ACK;
              end
            end
          end
        end
        // First SCL fall (end of bit 8) grabs SDA, the second releases it.
        ADDR_ACK, SUB_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = (state_q == ADDR_ACK) ? SUB : DATA;
            end
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe    <= sda_oe_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      busy      <= busy_d;
    end
  end
endmodule

// File: tb/tb_i2c_reg_writer.sv
// Directed bench: bit-banged I2C master with open-drain SDA and a strobe monitor.
module tb_i2c_reg_writer;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_in;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data;

  assign sda_in = sda_m & ~sda_oe;

  i2c_reg_writer #(.DEV_ADDR(7'h2A), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int rise_cyc = 0;
  int errors = 0;
  int checks = 0;
  int dbl = 0;
  int oe_cnt = 0;
  logic wr_prev = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         lat;
  } strobe_t;
  strobe_t sq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    strobe_t s;
    if (wr_en) begin
      s.a = wr_addr;
      s.d = wr_data;
      s.lat = cyc - rise_cyc;
      sq.push_back(s);
      if (wr_prev) dbl++;
    end
    wr_prev = wr_en;
    if (sda_oe) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_scl(input logic v);
    scl_m = v;
    if (v) rise_cyc = cyc;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      step(8); sda_m = 1'b1; step(8); set_scl(1'b1); step(16);
    end
    sda_m = 1'b0; step(16); set_scl(1'b0);
  endtask

  task automatic i2c_stop();
    step(8); sda_m = 1'b0; step(8); set_scl(1'b1); step(16); sda_m = 1'b1; step(16);
  endtask

  // res = {oe 5 cycles after bit-8 fall, oe 6 cycles after, oe mid 9th clock}
  task automatic send_byte(input logic [7:0] b, input int nbits, input int gbit,
                           input bit rst_ack, output logic [2:0] res);
    res = 3'b000;
    for (int i = 7; i >= 8 - nbits; i--) begin
      step(8); sda_m = b[i];
      if (i == gbit) begin
        step(2); scl_m = 1'b1; step(1); scl_m = 1'b0; step(5);
      end else begin
        step(8);
      end
      set_scl(1'b1); step(16); set_scl(1'b0);
    end
    if (nbits < 8) return;
    step(5); res[2] = sda_oe; step(1); res[1] = sda_oe;
    if (rst_ack) begin
      rst = 1'b1; step(1);
      chk("rst_oe", 32'(sda_oe), 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0; step(1);
    end else begin
      step(2);
    end
    sda_m = 1'b1; step(8); set_scl(1'b1); step(8); res[0] = sda_oe; step(8); set_scl(1'b0);
  endtask

  task automatic wb(input string tag, input logic [7:0] b, input logic [2:0] exp);
    logic [2:0] r;
    send_byte(b, 8, -1, 1'b0, r);
    chk(tag, 32'(r), 32'(exp));
  endtask

  task automatic exp_strobe(input string tag, input int idx, input logic [7:0] a,
                            input logic [7:0] d);
    if (idx < sq.size())
      chk(tag, {8'h0, sq[idx].a, sq[idx].d, sq[idx].lat[7:0]}, {8'h0, a, d, 8'd6});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base, oe0;
    logic [2:0] r;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    step(3);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; step(10);

    // basic write, two data bytes
    base = sq.size();
    i2c_start();
    wb("t1_hdr_ack", 8'h54, 3'b011);
    chk("t1_busy", 32'(busy), 32'd1);
    wb("t1_sub_ack", 8'h10, 3'b011);
    wb("t1_d0_ack", 8'h55, 3'b011);
    wb("t1_d1_ack", 8'hAA, 3'b011);
    i2c_stop();
    chk("t1_busy_stop", 32'(busy), 32'd0);
    chk("t1_count", 32'(sq.size() - base), 32'd2);
    exp_strobe("t1_s0", base, 8'h10, 8'h55);
    exp_strobe("t1_s1", base + 1, 8'h11, 8'hAA);

    // wrong address
    base = sq.size();
    i2c_start();
    wb("t2_nak", 8'h56, 3'b000);
    chk("t2_busy", 32'(busy), 32'd0);
    i2c_stop();
    chk("t2_count", 32'(sq.size() - base), 32'd0);

    // read request is ignored
    base = sq.size();
    i2c_start();
    wb("t3_nak", 8'h55, 3'b000);
    oe0 = oe_cnt;
    send_byte(8'h12, 8, -1, 1'b0, r);
    send_byte(8'h34, 8, -1, 1'b0, r);
    i2c_stop();
    chk("t3_no_oe", 32'(oe_cnt - oe0), 32'd0);
    chk("t3_count", 32'(sq.size() - base), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);

    // pointer wrap
    base = sq.size();
    i2c_start();
    wb("t4_hdr_ack", 8'h54, 3'b011);
    wb("t4_sub_ack", 8'hFF, 3'b011);
    wb("t4_d0_ack", 8'h01, 3'b011);
    wb("t4_d1_ack", 8'h02, 3'b011);
    i2c_stop();
    chk("t4_count", 32'(sq.size() - base), 32'd2);
    exp_strobe("t4_s0", base, 8'hFF, 8'h01);
    exp_strobe("t4_s1", base + 1, 8'h00, 8'h02);

    // repeated START abandons a partial byte
    base = sq.size();
    i2c_start();
    wb("t5_hdr_ack", 8'h54, 3'b011);
    wb("t5_sub_ack", 8'h30, 3'b011);
    send_byte(8'h12, 4, -1, 1'b0, r);
    i2c_start();
    wb("t5_hdr2_ack", 8'h54, 3'b011);
    wb("t5_sub2_ack", 8'h20, 3'b011);
    wb("t5_d_ack", 8'h7E, 3'b011);
    i2c_stop();
    chk("t5_count", 32'(sq.size() - base), 32'd1);
    exp_strobe("t5_s0", base, 8'h20, 8'h7E);

    // single-cycle SCL glitches are filtered out
    base = sq.size();
    i2c_start();
    send_byte(8'h54, 8, 3, 1'b0, r);
    chk("t6_hdr_ack", 32'(r), 32'(3'b011));
    wb("t6_sub_ack", 8'h40, 3'b011);
    send_byte(8'hC3, 8, 5, 1'b0, r);
    chk("t6_d_ack", 32'(r), 32'(3'b011));
    i2c_stop();
    chk("t6_count", 32'(sq.size() - base), 32'd1);
    exp_strobe("t6_s0", base, 8'h40, 8'hC3);

    // reset in the middle of the address ACK
    base = sq.size();
    i2c_start();
    send_byte(8'h54, 8, -1, 1'b1, r);
    chk("t7_ack_after_rst", 32'(r), 32'(3'b010));
    i2c_stop();
    chk("t7_count", 32'(sq.size() - base), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);

    chk("no_back_to_back", 32'(dbl), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
